// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
//   Round-robin arbiter for the shared system bus. Grants ownership to one of
//   four masters at a time; ownership is held until the owner releases its
//   request. Grants are registered; handover between masters is zero-bubble.
//
//   Optional watchdog: define BUS_ARB_TIMEOUT_EN to revoke a grant that has
//   been held for TIMEOUT_CYCLES cycles while another master waits. Without
//   the macro no counter exists and arb_timeout is constant 0.
//
// Parameters
//   TIMEOUT_CYCLES  cycles a grant may be held while others wait
//   TMR_W           watchdog counter width (2**TMR_W > TIMEOUT_CYCLES)
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   m0..m3_req_    bus requests, active-low
//   m0..m3_grnt_   bus grants, active-low, registered, at most one low
//   owner          index of current/last owner (master mux select)
//   bus_busy       high while any grant is asserted
//   arb_timeout    one-cycle pulse when the watchdog revokes a grant
// ---------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TMR_W          = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       bus_busy,
  output logic       arb_timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q;
  logic [3:0] grnt_q;      // active-low grants
  logic [1:0] owner_q;
  logic       timeout_q;

  logic [3:0] req_act;     // active-high requests
  logic [3:0] others;      // requests excluding the current owner
  logic       owner_req;
  logic       others_wait;
  logic [2:0] pick_all;    // {found, index}
  logic [2:0] pick_other;
  logic       revoke;

  // First requester found starting at 'start' and wrapping through 0..3.
  function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!res[2] && req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    req_act     = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    owner_req   = req_act[owner_q];
    others      = req_act & ~(4'b0001 << owner_q);
    others_wait = |others;
    pick_all    = rr_pick(req_act, owner_q + 2'd1);
    pick_other  = rr_pick(others, owner_q + 2'd1);
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [TMR_W-1:0] wd_cnt;

  assign revoke = (state_q == GRANT) && owner_req && others_wait &&
                  (wd_cnt == TMR_W'(TIMEOUT_CYCLES - 1));

  // Counts only while the owner holds and someone else waits; any grant
  // change (release or revoke) and any cycle with nobody waiting clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wd_cnt <= '0;
    else if ((state_q == GRANT) && owner_req && others_wait && !revoke)
      wd_cnt <= wd_cnt + 1'b1;
    else
      wd_cnt <= '0;
  end
`else
  // Parameters are only meaningful with the watchdog; the width check is
  // folded in here so both remain referenced in this build.
  localparam bit CFG_OK = ((2 ** TMR_W) > TIMEOUT_CYCLES);
  assign revoke = 1'b0 & CFG_OK;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grnt_q    <= '1;
      owner_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Owner itself is eligible here (searched last), which gives the
          // re-grant-after-one-idle-cycle behaviour.
          if (pick_all[2]) begin
            grnt_q  <= ~(4'b0001 << pick_all[1:0]);
            owner_q <= pick_all[1:0];
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req || revoke) begin
            timeout_q <= revoke;
            if (pick_other[2]) begin
              grnt_q  <= ~(4'b0001 << pick_other[1:0]);
              owner_q <= pick_other[1:0];
            end else begin
              grnt_q  <= '1;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          grnt_q  <= '1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m0_grnt_    = grnt_q[0];
  assign m1_grnt_    = grnt_q[1];
  assign m2_grnt_    = grnt_q[2];
  assign m3_grnt_    = grnt_q[3];
  assign owner       = owner_q;
  assign bus_busy    = ~&grnt_q;
  assign arb_timeout = timeout_q;

endmodule
